ps2_mouse_decoder: RTL and testbench
====================================

Name: ps2_mouse_decoder

Overview:
- Mouse-side producer of the pointer interface consumed by the game core: `x_pos`, `y_pos`, `left_btn` and `right_btn`.
- Receives the raw PS/2 clock/data lines from a stream-mode mouse, deserialises 11-bit frames and assembles 3-byte movement packets.
- Integrates signed deltas into a saturating screen coordinate.
- Receive-only: the mouse-enable command (0xF4) is issued by a separate host-transmit block.

Parameters:
- X_MAX, 639, largest legal x_pos
- Y_MAX, 479, largest legal y_pos
- X_INIT, 320, x_pos after reset
- Y_INIT, 240, y_pos after reset
- TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge that abort a partial frame and packet

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- ps2_data  in  1  raw PS/2 data line (asynchronous)
- x_pos  out  12  cursor X, 0..X_MAX
- y_pos  out  12  cursor Y, 0..Y_MAX, screen-down positive
- left_btn  out  1  left button state from last accepted packet
- right_btn  out  1  right button state from last accepted packet
- packet_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, left_btn=0, right_btn=0, packet_valid=0, frame and packet state cleared.
- Input sync: `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A falling edge is detected as prev=1, cur=0 on the synced clock. Data is sampled on that same cycle.
- Frame FSM, states IDLE, BITS, PARITY, STOP:
  - IDLE: a falling edge with data=0 (start) goes to BITS. A start bit of 1 is ignored and the FSM stays in IDLE.
  - BITS: 8 edges, data shifted in LSB first, then PARITY.
  - PARITY: sampled bit must make data+parity odd; the result is recorded. Next is STOP.
  - STOP: stop bit must be 1. A byte is accepted only if parity is OK and stop=1; otherwise a byte error is raised. Returns to IDLE in every case.
- Timeout: an idle-edge counter resets on every falling edge. If it reaches TIMEOUT_CYCLES while the frame FSM is not in IDLE, or a packet is partially assembled, the frame returns to IDLE and the byte index goes to 0. There is no output change.
- Packet assembly, byte index 0..2:
  - Index 0 accepts a byte only if bit3=1; otherwise the byte is discarded and the index stays 0 (resync).
  - Indices 1 and 2 accept any byte.
  - A byte error at any index discards the packet and sets the index to 0.
- Packet fields:
  - b0[0]=left, b0[1]=right.
  - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
  - b0[6]=X overflow, b0[7]=Y overflow.
- Update: one clk after the cycle that accepts byte 2, in a single cycle:
  - left_btn and right_btn are loaded.
  - If X overflow is clear, new_x = x_pos + sext(dx), computed in 14-bit signed and clamped to [0, X_MAX]. If set, x is unchanged.
  - If Y overflow is clear, new_y = y_pos − sext(dy), clamped to [0, Y_MAX], because PS/2 up is positive. If set, y is unchanged.
  - packet_valid=1 in that same cycle only.
- Timing:
  - Latency from the falling edge of byte 2's stop bit on the raw pin to packet_valid is 2 sync cycles + 1 detect cycle + 1 update cycle.
  - Outputs hold between packets.
- Reset mid-frame or mid-packet discards everything and restores the reset values on the next clk edge.
- Back-to-back packets must be handled with no dead time beyond the protocol's own bit timing.

Test Plan:
- Reset: assert reset 2 cycles -> x_pos=320, y_pos=240, left_btn=0, right_btn=0, packet_valid=0.
- Basic packet: send 0x09, 0x10, 0x05 with correct parity -> exactly one packet_valid pulse; x_pos=336, y_pos=235, left_btn=1, right_btn=0.
- Clamp:
  - Move to x=10, then send 0x18, 0xEC, 0x00 (dx=−20) -> x_pos=0, y unchanged.
  - Send 0x08, 0xFF, 0x00 three times from x=600 -> x_pos=639.
- Overflow: send 0x4A, 0x55, 0x00 -> right_btn=1, left_btn=0, x_pos and y_pos unchanged, packet_valid pulses.
- Parity error then resync: corrupt parity on byte 1 of a packet -> no pulse, outputs unchanged. Next valid packet 0x08, 0x01, 0x00 -> x_pos increments by 1. Also send a stray 0x00 as the first byte -> discarded, and the following good packet is decoded.
- Timeout: send a start bit plus 4 data bits, idle for 100001 cycles, then send the full packet 0x08, 0x02, 0x00 -> x_pos increments by 2 with a single packet_valid. Repeat with reset asserted mid-byte -> reset values, no pulse.

Source files
------------

// File: rtl/ps2_mouse_decoder_if.sv
// ps2_mouse_decoder_if: pointer bus (x_pos, y_pos, left_btn, right_btn, packet_valid) from decoder (master) to game core (slave)
interface ps2_mouse_decoder_if;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        left_btn;
  logic        right_btn;
  logic        packet_valid;
  modport master(output x_pos, y_pos, left_btn, right_btn, packet_valid);
  modport slave(input x_pos, y_pos, left_btn, right_btn, packet_valid);
endinterface

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder: PS/2 stream-mode mouse receiver; clk/reset, raw ps2_clk/ps2_data in, saturating cursor and buttons out on ptr
module ps2_mouse_decoder #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_mouse_decoder_if.master   ptr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BITS, PARITY, STOP} state_t;
  state_t          state, state_n;
  logic [1:0]      ck_s, dt_s;
  logic            ck_prev, fall, d;
  logic [CW-1:0]   idle_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      sh;
  logic            par_ok;
  logic [1:0]      idx;
  logic [5:0]      b0;
  logic [7:0]      b1;
  logic            timeout, byte_done, byte_ok, byte_err, pkt_done;
  logic [8:0]      dx, dy;
  logic [13:0]     nx, ny;
  logic [11:0]     cx, cy;
  always_comb begin
    fall      = ck_prev & ~ck_s[1];
    d         = dt_s[1];
    timeout   = (idle_cnt == CW'(TIMEOUT_CYCLES)) && (state != IDLE || idx != 2'd0);
    byte_done = fall && state == STOP && !timeout;
    byte_ok   = byte_done && par_ok && d;
    byte_err  = byte_done && !byte_ok;
    pkt_done  = byte_ok && idx == 2'd2;
    dx        = {b0[2], b1};
    dy        = {b0[3], sh};
    nx        = {2'b00, ptr.x_pos} + {{5{dx[8]}}, dx};
    ny        = {2'b00, ptr.y_pos} - {{5{dy[8]}}, dy};
    cx        = nx[13] ? 12'd0 : (nx > 14'(X_MAX)) ? 12'(X_MAX) : nx[11:0];
    cy        = ny[13] ? 12'd0 : (ny > 14'(Y_MAX)) ? 12'(Y_MAX) : ny[11:0];
    state_n   = state;
    if (timeout)
      state_n = IDLE;
    else if (fall)
      case (state)
        IDLE:    state_n = d ? IDLE : BITS;
        BITS:    state_n = (bit_cnt == 3'd7) ? PARITY : BITS;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ck_s             <= 2'b11;
      dt_s             <= 2'b11;
      ck_prev          <= 1'b1;
      state            <= IDLE;
      idle_cnt         <= '0;
      bit_cnt          <= '0;
      sh               <= '0;
      par_ok           <= 1'b0;
      idx              <= '0;
      b0               <= '0;
      b1               <= '0;
      ptr.x_pos        <= 12'(X_INIT);
      ptr.y_pos        <= 12'(Y_INIT);
      ptr.left_btn     <= 1'b0;
      ptr.right_btn    <= 1'b0;
      ptr.packet_valid <= 1'b0;
    end else begin
      ck_s             <= {ck_s[0], ps2_clk};
      dt_s             <= {dt_s[0], ps2_data};
      ck_prev          <= ck_s[1];
      state            <= state_n;
      idle_cnt         <= fall ? '0 : (idle_cnt == CW'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
      ptr.packet_valid <= pkt_done;
      if (fall && state == IDLE)
        bit_cnt <= '0;
      if (fall && state == BITS) begin
        sh      <= {d, sh[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY)
        par_ok <= ^{sh, d};
      if (timeout || byte_err)
        idx <= 2'd0;
      else if (byte_ok)
        case (idx)
          2'd0: if (sh[3]) begin
            b0  <= {sh[7:4], sh[1:0]};
            idx <= 2'd1;
          end
          2'd1: begin
            b1  <= sh;
            idx <= 2'd2;
          end
          default: idx <= 2'd0;
        endcase
      if (pkt_done) begin
        ptr.left_btn  <= b0[0];
        ptr.right_btn <= b0[1];
        if (!b0[4])
          ptr.x_pos <= cx;
        if (!b0[5])
          ptr.y_pos <= cy;
      end
    end
  end
endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder: directed bench driving PS/2 frames into ps2_mouse_decoder and checking the pointer bus
module tb_ps2_mouse_decoder;
  localparam int HALF = 5;
  localparam int TMO  = 300;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   p0;
  ps2_mouse_decoder_if bus();
  ps2_mouse_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ptr(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.packet_valid) pulses++;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
  endtask
  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b0);
    send_byte(b, 1'b0);
    send_byte(c, 1'b0);
    repeat (5) @(negedge clk);
  endtask
  task automatic chk_xy(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(bus.x_pos), x);
    chk({tag, "_y"}, int'(bus.y_pos), y);
  endtask
  task automatic chk_btn(input string tag, input int l, input int r);
    chk({tag, "_left"}, int'(bus.left_btn), l);
    chk({tag, "_right"}, int'(bus.right_btn), r);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_xy("reset", 320, 240);
    chk_btn("reset", 0, 0);
    chk("reset_pv", int'(bus.packet_valid), 0);
    p0 = pulses;
    send_pkt(8'h09, 8'h10, 8'h05);
    chk("basic_pulses", pulses - p0, 1);
    chk_xy("basic", 336, 235);
    chk_btn("basic", 1, 0);
    chk("basic_pv_low", int'(bus.packet_valid), 0);
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'hBA, 8'h00);
    chk_xy("move_x10", 10, 235);
    send_pkt(8'h18, 8'hEC, 8'h00);
    chk_xy("clamp_low", 0, 235);
    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'h5A, 8'h00);
    chk_xy("move_x600", 600, 235);
    p0 = pulses;
    for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'hFF, 8'h00);
    chk("clamp_high_pulses", pulses - p0, 3);
    chk_xy("clamp_high", 639, 235);
    send_pkt(8'h28, 8'h00, 8'h00);
    chk_xy("clamp_ymax", 639, 479);
    p0 = pulses;
    send_pkt(8'h4A, 8'h55, 8'h00);
    chk("ovf_pulses", pulses - p0, 1);
    chk_xy("ovf", 639, 479);
    chk_btn("ovf", 0, 1);
    send_pkt(8'h18, 8'h00, 8'h00);
    chk_xy("back_left", 383, 479);
    p0 = pulses;
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (5) @(negedge clk);
    chk("parity_pulses", pulses - p0, 0);
    chk_xy("parity", 383, 479);
    send_pkt(8'h08, 8'h01, 8'h00);
    chk_xy("resync", 384, 479);
    p0 = pulses;
    send_byte(8'h00, 1'b0);
    send_pkt(8'h09, 8'h01, 8'h00);
    chk("stray_pulses", pulses - p0, 1);
    chk_xy("stray", 385, 479);
    chk_btn("stray", 1, 0);
    p0 = pulses;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    chk("timeout_idle_pulses", pulses - p0, 0);
    send_pkt(8'h08, 8'h02, 8'h00);
    chk("timeout_pulses", pulses - p0, 1);
    chk_xy("timeout", 387, 479);
    p0 = pulses;
    send_byte(8'h08, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_xy("midreset", 320, 240);
    chk_btn("midreset", 0, 0);
    chk("midreset_pulses", pulses - p0, 0);
    reset = 1'b0;
    send_pkt(8'h08, 8'h03, 8'h00);
    chk("after_reset_pulses", pulses - p0, 1);
    chk_xy("after_reset", 323, 240);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
